// File: rtl/rtc_pkg.sv
// Shared types and the RTC power-up register table for the init writer.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSO = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5
    } estado_t;

    typedef enum logic {
        ADDR = 1'b0,
        DATA = 1'b1
    } fase_t;

    // Entry 0 is the rightmost element.
    localparam logic [7:0][7:0] INIT_DIR = {
        8'h00, 8'h00, 8'h00, 8'hF1, 8'h00, 8'h10, 8'h02, 8'h02
    };
    localparam logic [7:0][7:0] INIT_DAT = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'hD2, 8'h00, 8'h10
    };

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rtc_init_escritor_temporizador.sv
// Loadable down-counter; holds at zero until reloaded.
module rtc_temporizador #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] valor,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= valor;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_init_escritor.sv
// Walks the init table and drives the RTC multiplexed address/data write cycles.
module rtc_init_escritor
    import rtc_pkg::*;
#(
    parameter int N_PASOS = 5,
    parameter int T_SETUP = 2,
    parameter int T_PULSO = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] paso,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ad,
    output logic [7:0] dato_out,
    output logic       oe
);

    localparam int TW = $clog2(max4(T_SETUP, T_PULSO, T_HOLD, T_GAP)) + 1;
    localparam logic [2:0] ULTIMO = 3'(N_PASOS - 1);

    estado_t       state;
    fase_t         fase;
    logic          load;
    logic [TW-1:0] valor;
    logic          zero;
    logic          ultimo;

    assign ultimo = (fase == DATA) && (paso == ULTIMO);
    assign rd_n   = 1'b1;

    // Reload the timer on every state change with the next state's length.
    always_comb begin
        load  = 1'b0;
        valor = '0;
        unique case (state)
            IDLE: begin
                load  = start;
                valor = TW'(T_SETUP - 1);
            end
            SETUP: begin
                load  = zero;
                valor = TW'(T_PULSO - 1);
            end
            PULSO: begin
                load  = zero;
                valor = TW'(T_HOLD - 1);
            end
            HOLD: begin
                load  = zero;
                valor = TW'(T_GAP - 1);
            end
            GAP: begin
                load  = zero && !ultimo;
                valor = TW'(T_SETUP - 1);
            end
            default: begin
                load  = 1'b0;
                valor = '0;
            end
        endcase
    end

    rtc_temporizador #(.W(TW)) u_tmr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .valor (valor),
        .zero  (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fase     <= ADDR;
            paso     <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            ad       <= 1'b0;
            dato_out <= 8'h00;
            oe       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        fase     <= ADDR;
                        paso     <= 3'd0;
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        oe       <= 1'b1;
                        ad       <= 1'b1;
                        dato_out <= INIT_DIR[0];
                    end
                end
                SETUP: begin
                    if (zero) begin
                        state <= PULSO;
                        wr_n  <= 1'b0;
                    end
                end
                PULSO: begin
                    if (zero) begin
                        state <= HOLD;
                        wr_n  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (zero) begin
                        state <= GAP;
                        cs_n  <= 1'b1;
                        oe    <= 1'b0;
                    end
                end
                GAP: begin
                    if (zero) begin
                        if (fase == ADDR) begin
                            state    <= SETUP;
                            fase     <= DATA;
                            cs_n     <= 1'b0;
                            oe       <= 1'b1;
                            ad       <= 1'b0;
                            dato_out <= INIT_DAT[paso];
                        end else if (ultimo) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= SETUP;
                            fase     <= ADDR;
                            paso     <= paso + 3'd1;
                            cs_n     <= 1'b0;
                            oe       <= 1'b1;
                            ad       <= 1'b1;
                            dato_out <= INIT_DIR[paso + 3'd1];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_init_escritor.sv
// Scoreboard bench: expected write pulses are queued, monitors pop on wr_n falling.
module tb_rtc_init_escritor;

    logic clk = 1'b0;
    logic reset, start, start_b;

    logic       a_busy, a_done, a_cs, a_wr, a_rd, a_ad, a_oe;
    logic [2:0] a_paso;
    logic [7:0] a_dato;
    logic       b_busy, b_done, b_cs, b_wr, b_rd, b_ad, b_oe;
    logic [2:0] b_paso;
    logic [7:0] b_dato;

    int vectors = 0;
    int errors  = 0;

    logic [11:0] qa[$];
    logic [8:0]  qb[$];

    // {paso, ad, dato} under each wr_n low pulse
    logic [11:0] exp_a [10] = '{
        12'h102, 12'h010, 12'h302, 12'h200, 12'h510,
        12'h4D2, 12'h700, 12'h604, 12'h9F1, 12'h800
    };

    always #5 clk = ~clk;

    rtc_init_escritor dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (a_busy),
        .done     (a_done),
        .paso     (a_paso),
        .cs_n     (a_cs),
        .wr_n     (a_wr),
        .rd_n     (a_rd),
        .ad       (a_ad),
        .dato_out (a_dato),
        .oe       (a_oe)
    );

    rtc_init_escritor #(
        .N_PASOS (1),
        .T_SETUP (1),
        .T_PULSO (1),
        .T_HOLD  (1),
        .T_GAP   (1)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start_b),
        .busy     (b_busy),
        .done     (b_done),
        .paso     (b_paso),
        .cs_n     (b_cs),
        .wr_n     (b_wr),
        .rd_n     (b_rd),
        .ad       (b_ad),
        .dato_out (b_dato),
        .oe       (b_oe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the default-parameter instance
    logic        pw = 1, pc = 1, inseq = 0;
    int          lo = 0, cslo = 0, wrhi = 0, cshi = 0;
    logic [12:0] snap;

    always @(negedge clk) begin
        if (reset) begin
            pw = 1; pc = 1; inseq = 0;
            lo = 0; cslo = 0; wrhi = 0; cshi = 0;
        end else begin
            cslo = a_cs ? 0 : cslo + 1;
            wrhi = a_wr ? wrhi + 1 : 0;
            if (!a_wr && pw) begin
                chk("cs_to_wr", cslo, 3);
                if (qa.size() == 0) chk("unexpected_pulse", 1, 0);
                else chk("pulse_data", {a_paso, a_ad, a_dato}, qa.pop_front());
                snap = {a_cs, a_paso, a_ad, a_dato};
                lo = 1;
            end else if (!a_wr) begin
                lo++;
                chk("stable_low", {a_cs, a_paso, a_ad, a_dato}, snap);
            end
            if (a_wr && !pw) chk("pulse_len", lo, 4);
            if (a_cs && !pc) begin
                chk("wr_to_cs", wrhi, 3);
                chk("oe_off", a_oe, 0);
            end
            if (!a_cs && pc) begin
                if (inseq) chk("gap_len", cshi, 2);
                chk("oe_on", a_oe, 1);
                inseq = 1;
            end
            cshi = a_cs ? cshi + 1 : 0;
            if (a_done) inseq = 0;
            pw = a_wr;
            pc = a_cs;
        end
    end

    // Monitor for the minimal-timing instance
    logic pwb = 1;
    int   lob = 0;

    always @(negedge clk) begin
        if (reset) begin
            pwb = 1; lob = 0;
        end else begin
            if (!b_wr && pwb) begin
                if (qb.size() == 0) chk("b_unexpected_pulse", 1, 0);
                else chk("b_pulse_data", {b_ad, b_dato}, qb.pop_front());
                lob = 1;
            end else if (!b_wr) begin
                lob++;
            end
            if (b_wr && !pwb) chk("b_pulse_len", lob, 1);
            pwb = b_wr;
        end
    end

    task automatic quiet_check(input string name, input int cycles);
        int nd, nbz;
        nd = 0; nbz = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            nd  += a_done;
            nbz += a_busy;
        end
        chk({name, "_no_done"}, nd, 0);
        chk({name, "_no_busy"}, nbz, 0);
    endtask

    task automatic run_seq(input bit retrig);
        int  n, nb;
        bit  seen;
        foreach (exp_a[i]) qa.push_back(exp_a[i]);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        n = 0; nb = a_busy; seen = 0;
        while (n < 300 && !seen) begin
            if (retrig && (n == 5 || n == 50)) start = 1;
            @(posedge clk); n++; #1;
            start = 0;
            if (a_done) seen = 1;
            else if (a_busy) nb++;
        end
        chk("done_latency", n, 100);
        chk("busy_cycles", nb, 100);
        chk("busy_at_done", a_busy, 0);
        if (retrig) start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("done_single", a_done, 0);
        chk("queue_drained", qa.size(), 0);
        quiet_check("after_seq", 20);
    endtask

    initial begin
        int n, nd;
        reset = 1; start = 0; start_b = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_cs", a_cs, 1);
        chk("rst_wr", a_wr, 1);
        chk("rst_rd", a_rd, 1);
        chk("rst_ad", a_ad, 0);
        chk("rst_oe", a_oe, 0);
        chk("rst_dato", a_dato, 0);
        chk("rst_paso", a_paso, 0);
        chk("rst_done", a_done, 0);
        chk("rst_b_rd", b_rd, 1);
        chk("rst_b_oe", b_oe, 0);
        quiet_check("idle", 20);

        // Minimal timing: two pulses, done 8 edges after start
        qb.push_back(9'h102);
        qb.push_back(9'h010);
        @(posedge clk); #1 start_b = 1;
        @(posedge clk); #1 start_b = 0;
        n = 0;
        while (n < 50 && !b_done) begin
            @(posedge clk); n++; #1;
        end
        chk("b_done_latency", n, 8);
        chk("b_busy_at_done", b_busy, 0);
        chk("b_paso", b_paso, 0);
        chk("b_queue_drained", qb.size(), 0);
        repeat (3) @(posedge clk);

        run_seq(1'b1);
        run_seq(1'b0);

        // Abort during the PULSO of step 2 DATA (phase 5 starts at edge 50)
        for (int i = 0; i < 10; i++) qa.push_back(exp_a[i]);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        n = 0;
        while (n < 53) begin
            @(posedge clk); n++; #1;
        end
        chk("abort_in_pulse", {a_wr, a_ad, a_paso}, {1'b0, 1'b0, 3'd2});
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("abort_wr", a_wr, 1);
        chk("abort_cs", a_cs, 1);
        chk("abort_oe", a_oe, 0);
        chk("abort_paso", a_paso, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_left", qa.size(), 4);
        qa.delete();
        nd = 0;
        repeat (10) begin
            @(posedge clk); #1;
            nd += a_done;
        end
        chk("abort_no_done", nd, 0);

        run_seq(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
